// File: rtl/serial_addsub_if.sv
// Operand/result bundle for serial_addsub. start, sub, x, y and cin are sampled
// by the unit only on an accepted start; busy/done/z/cout/ovf/state are unit-driven.
interface serial_addsub_if #(parameter int WIDTH = 8);
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] z;
  logic             cout;
  logic             ovf;
  logic [1:0]       state;

  modport master (output start, sub, cin, x, y,
                  input  busy, done, z, cout, ovf, state);
  modport slave  (input  start, sub, cin, x, y,
                  output busy, done, z, cout, ovf, state);
endinterface

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor, STEP bits per clock with a registered carry.
// Define ADDSUB_OVF_EN to compute signed overflow; otherwise ovf is tied to 0.
module serial_addsub #(
   parameter int WIDTH = 8,
   parameter int STEP  = 1
) (
   input logic            clk,
   input logic            rst,
   serial_addsub_if.slave bus
);

   localparam int N  = WIDTH / STEP;
   localparam int CW = $clog2(N) + 1;

   // Handshake: start is accepted on any rising edge where the unit is not in RUN
   // (IDLE or DONE); done is high for exactly the one cycle after the last step.
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, part_q, part_d, sum_ext;
   logic             carry_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] z_q;
   logic             cout_q;
   logic [STEP:0]    step_sum;
   logic             last, accept;

   assign step_sum = {1'b0, a_q[STEP-1:0]} + {1'b0, b_q[STEP-1:0]} + {{STEP{1'b0}}, carry_q};
   assign sum_ext  = WIDTH'(step_sum[STEP-1:0]);
   assign part_d   = (part_q >> STEP) | (sum_ext << (WIDTH - STEP));
   assign last     = (cnt_q == CW'(N - 1));
   assign accept   = bus.start && (state_q != RUN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = RUN;
         RUN:     if (last)      state_d = DONE;
         DONE:    state_d = bus.start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         part_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         z_q     <= '0;
         cout_q  <= 1'b0;
      end else if (accept) begin
         a_q     <= bus.x;
         b_q     <= bus.sub ? ~bus.y : bus.y;
         carry_q <= bus.cin ^ bus.sub;
         cnt_q   <= '0;
      end else if (state_q == RUN) begin
         a_q     <= a_q >> STEP;
         b_q     <= b_q >> STEP;
         carry_q <= step_sum[STEP];
         part_q  <= part_d;
         cnt_q   <= cnt_q + CW'(1);
         if (last) begin
            z_q    <= part_d;
            cout_q <= step_sum[STEP];
         end
      end
   end

`ifdef ADDSUB_OVF_EN
   // Carry into the MSB recovered from its sum bit: s = a ^ b ^ c_in.
   logic ovf_q;
   logic cmsb;
   assign cmsb = a_q[STEP-1] ^ b_q[STEP-1] ^ step_sum[STEP-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                            ovf_q <= 1'b0;
      else if (state_q == RUN && last)    ovf_q <= cmsb ^ step_sum[STEP];
   end
   assign bus.ovf = ovf_q;
`else
   assign bus.ovf = 1'b0;
`endif

   assign bus.busy  = (state_q == RUN);
   assign bus.done  = (state_q == DONE);
   assign bus.z     = z_q;
   assign bus.cout  = cout_q;
   assign bus.state = state_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: three instances (8/1, 8/4, 4/2) checked against an
// arithmetic reference model, including back-to-back, mid-run reset and a 4-bit sweep.
module tb_serial_addsub;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(8)) b1 ();
  serial_addsub_if #(.WIDTH(8)) b4 ();
  serial_addsub_if #(.WIDTH(4)) b2 ();

  serial_addsub #(.WIDTH(8), .STEP(1)) d1 (.clk(clk), .rst(rst), .bus(b1));
  serial_addsub #(.WIDTH(8), .STEP(4)) d4 (.clk(clk), .rst(rst), .bus(b4));
  serial_addsub #(.WIDTH(4), .STEP(2)) d2 (.clk(clk), .rst(rst), .bus(b2));

  int total = 0;
  int bad   = 0;
  logic [9:0] exp_q[$];

  // {cout, ovf, z}: full-precision sum, overflow when equal-signed operands give a different sign
  function automatic logic [9:0] model8(input logic [7:0] x, y, input logic sub, cin);
    logic [8:0] full;
    logic [7:0] yy;
    logic ov;
    yy   = sub ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + {8'd0, cin ^ sub};
    ov   = (x[7] == yy[7]) && (full[7] != x[7]);
`ifndef ADDSUB_OVF_EN
    ov = 1'b0;
`endif
    return {full[8], ov, full[7:0]};
  endfunction

  function automatic logic [5:0] model4(input logic [3:0] x, y, input logic sub, cin);
    logic [4:0] full;
    logic [3:0] yy;
    logic ov;
    yy   = sub ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + {4'd0, cin ^ sub};
    ov   = (x[3] == yy[3]) && (full[3] != x[3]);
`ifndef ADDSUB_OVF_EN
    ov = 1'b0;
`endif
    return {full[4], ov, full[3:0]};
  endfunction

  task automatic run1(input logic [7:0] x, y, input logic sub, cin, input string name);
    logic [9:0] e;
    logic [7:0] prev_z;
    int cyc;
    e      = model8(x, y, sub, cin);
    prev_z = b1.z;
    @(negedge clk);
    b1.x = x; b1.y = y; b1.sub = sub; b1.cin = cin; b1.start = 1'b1;
    @(posedge clk); #1;
    b1.start = 1'b0;
    b1.x = 8'($urandom); b1.y = 8'($urandom); b1.sub = 1'($urandom); b1.cin = 1'($urandom);
    cyc = 0;
    while (!b1.done && cyc < 20) begin
      total++;
      if (b1.busy !== 1'b1 || b1.z !== prev_z) begin
        bad++;
        $display("FAIL %s run: busy=%b z=%h required busy=1 z=%h", name, b1.busy, b1.z, prev_z);
      end
      @(posedge clk); #1;
      cyc++;
    end
    total++;
    if (cyc !== 8 || b1.busy !== 1'b0) begin
      bad++;
      $display("FAIL %s latency: done after %0d cycles busy=%b required 8 busy=0", name, cyc, b1.busy);
    end
    total++;
    if ({b1.cout, b1.ovf, b1.z} !== e) begin
      bad++;
      $display("FAIL %s result: cout/ovf/z=%b/%b/%h required %b/%b/%h",
               name, b1.cout, b1.ovf, b1.z, e[9], e[8], e[7:0]);
    end
    @(posedge clk); #1;
    total++;
    if (b1.done !== 1'b0 || b1.busy !== 1'b0) begin
      bad++;
      $display("FAIL %s done_fall: done=%b busy=%b required 0/0", name, b1.done, b1.busy);
    end
  endtask

  task automatic run4(input logic [7:0] x, y, input logic sub, cin, input string name);
    logic [9:0] e;
    int cyc;
    e = model8(x, y, sub, cin);
    @(negedge clk);
    b4.x = x; b4.y = y; b4.sub = sub; b4.cin = cin; b4.start = 1'b1;
    @(posedge clk); #1;
    b4.start = 1'b0;
    cyc = 0;
    while (!b4.done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    total++;
    if (cyc !== 2) begin
      bad++;
      $display("FAIL %s latency: done after %0d cycles required 2", name, cyc);
    end
    total++;
    if ({b4.cout, b4.ovf, b4.z} !== e) begin
      bad++;
      $display("FAIL %s result: cout/ovf/z=%b/%b/%h required %b/%b/%h",
               name, b4.cout, b4.ovf, b4.z, e[9], e[8], e[7:0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({b1.busy, b1.done, b1.z, b1.cout, b1.ovf, b1.state} !== 13'd0) begin
      bad++;
      $display("FAIL reset_d1: busy=%b done=%b z=%h cout=%b ovf=%b state=%0d required all 0",
               b1.busy, b1.done, b1.z, b1.cout, b1.ovf, b1.state);
    end
    total++;
    if ({b4.busy, b4.done, b4.z, b4.cout, b4.ovf} !== 11'd0 ||
        {b2.busy, b2.done, b2.z, b2.cout, b2.ovf} !== 7'd0) begin
      bad++;
      $display("FAIL reset_d4_d2: d4 z=%h busy=%b d2 z=%h busy=%b required 0", b4.z, b4.busy, b2.z, b2.busy);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed;
    run1(8'h5A, 8'h33, 1'b0, 1'b0, "add_5a_33");
    run1(8'h10, 8'h20, 1'b1, 1'b0, "sub_10_20");
    run1(8'h10, 8'h20, 1'b1, 1'b1, "sub_10_20_cin");
    run1(8'h7F, 8'h01, 1'b0, 1'b0, "add_pos_ovf");
    run1(8'h80, 8'h01, 1'b1, 1'b0, "sub_neg_ovf");
    run4(8'hFF, 8'h01, 1'b0, 1'b0, "step4_ff_01");
    run4(8'h80, 8'h80, 1'b0, 1'b1, "step4_80_80");
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++) begin
      run1(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), "rand_s1");
      run4(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), "rand_s4");
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] x, y;
    logic s, c;
    logic [9:0] e, got;
    exp_q.delete();
    @(negedge clk);
    for (int cyc = 0; cyc < 45; cyc++) begin
      if (cyc > 0) @(negedge clk);
      x = 8'($urandom); y = 8'($urandom); s = 1'($urandom_range(0, 1)); c = 1'($urandom_range(0, 1));
      b1.x = x; b1.y = y; b1.sub = s; b1.cin = c; b1.start = 1'b1;
      if (cyc % 9 == 0) exp_q.push_back(model8(x, y, s, c));
      @(posedge clk); #1;
      total++;
      if (b1.busy && b1.done) begin
        bad++;
        $display("FAIL b2b_overlap: busy=1 done=1 at cycle %0d required not both", cyc);
      end
      total++;
      if (b1.done !== (cyc % 9 == 8)) begin
        bad++;
        $display("FAIL b2b_done_timing: done=%b at cycle %0d required %b", b1.done, cyc, (cyc % 9 == 8));
      end
      if (b1.done) begin
        got = {b1.cout, b1.ovf, b1.z};
        e   = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3FF;
        total++;
        if (got !== e) begin
          bad++;
          $display("FAIL b2b_result: cout/ovf/z=%b/%b/%h required %b/%b/%h",
                   got[9], got[8], got[7:0], e[9], e[8], e[7:0]);
        end
      end
    end
    b1.start = 1'b0;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL b2b_drain: %0d results outstanding required 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_run;
    logic seen_done;
    run1(8'h5A, 8'h33, 1'b0, 1'b0, "pre_reset");
    @(negedge clk);
    b1.x = 8'hC3; b1.y = 8'h1E; b1.sub = 1'b0; b1.cin = 1'b1; b1.start = 1'b1;
    @(posedge clk); #1;
    b1.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++;
    if ({b1.busy, b1.done, b1.z, b1.cout, b1.ovf} !== 11'd0) begin
      bad++;
      $display("FAIL midrun_reset: busy=%b done=%b z=%h cout=%b ovf=%b required all 0",
               b1.busy, b1.done, b1.z, b1.cout, b1.ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (b1.done || b1.busy) seen_done = 1'b1;
    end
    total++;
    if (seen_done !== 1'b0) begin
      bad++;
      $display("FAIL midrun_no_done: activity after reset=%b required 0", seen_done);
    end
    run1(8'hC3, 8'h1E, 1'b0, 1'b1, "post_reset");
  endtask

  task automatic test_sweep;
    logic [5:0] e;
    logic [3:0] prev_z;
    int cyc;
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < 2; c++)
        for (int xi = 0; xi < 16; xi++)
          for (int yi = 0; yi < 16; yi++) begin
            e      = model4(4'(xi), 4'(yi), 1'(s), 1'(c));
            prev_z = b2.z;
            @(negedge clk);
            b2.x = 4'(xi); b2.y = 4'(yi); b2.sub = 1'(s); b2.cin = 1'(c); b2.start = 1'b1;
            @(posedge clk); #1;
            b2.start = 1'b0;
            cyc = 0;
            while (!b2.done && cyc < 10) begin
              total++;
              if (b2.z !== prev_z || b2.busy !== 1'b1) begin
                bad++;
                $display("FAIL sweep_hold: z=%h busy=%b required z=%h busy=1", b2.z, b2.busy, prev_z);
              end
              @(posedge clk); #1;
              cyc++;
            end
            total++;
            if (cyc !== 2 || {b2.cout, b2.ovf, b2.z} !== e) begin
              bad++;
              $display("FAIL sweep x=%h y=%h sub=%0d cin=%0d: lat=%0d cout/ovf/z=%b/%b/%h required 2 %b/%b/%h",
                       xi, yi, s, c, cyc, b2.cout, b2.ovf, b2.z, e[5], e[4], e[3:0]);
            end
          end
  endtask

  initial begin
    rst = 1'b1;
    b1.start = 1'b0; b1.x = '0; b1.y = '0; b1.sub = 1'b0; b1.cin = 1'b0;
    b4.start = 1'b0; b4.x = '0; b4.y = '0; b4.sub = 1'b0; b4.cin = 1'b0;
    b2.start = 1'b0; b2.x = '0; b2.y = '0; b2.sub = 1'b0; b2.cin = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
